// File: rtl/drr_class_demux.sv
// Per-class demux: strips the 0x55 class header and steers the packet body to one of NUM_CLASSES outputs.
// Latency: a word is at the FIFO head 1 cycle after in_wr, and on out_* 1 cycle after it is popped.
// Backpressure: out_rdy[cls] gates pops only while forwarding; the 32-deep input FIFO drops in_rdy at 31 words.
module drr_class_demux #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int                    NUM_CLASSES = 5,
  parameter logic [CTRL_WIDTH-1:0] CLASS_CTRL  = CTRL_WIDTH'(8'h55)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  output logic                   in_rdy,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [NUM_CLASSES-1:0] out_wr,
  input  logic [NUM_CLASSES-1:0] out_rdy,
  output logic [NUM_CLASSES-1:0] class_pkt_pulse,
  output logic                   drop_pulse
);

  // Input FIFO geometry: 32 entries, in_rdy withdrawn once 31 are held so
  // one more in-flight word from the upstream still fits.
  localparam int FIFO_AW    = 5;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int CNT_W      = FIFO_AW + 1;
  localparam int WORD_W     = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_L = CNT_W'(31);
  // The class field in the header word is 3 bits wide.
  localparam logic [3:0] NUM_CLASSES_L = 4'(NUM_CLASSES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } state_t;

  // ------------------------------------------------------------------
  // Fallthrough input FIFO: the head entry is readable whenever non-empty.
  // ------------------------------------------------------------------
  logic [WORD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fifo_empty;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_pop;
  logic [WORD_W-1:0]  fifo_head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_wr    = in_wr && (cnt_q != DEPTH_L);
  assign fifo_rd    = fifo_pop && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign in_rdy     = (cnt_q < THRESH_L);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (fifo_wr && !fifo_rd) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!fifo_wr && fifo_rd) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= {in_ctrl, in_data};
    end
  end

  // ------------------------------------------------------------------
  // Packet steering FSM.
  // ------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [2:0]             cls_q, cls_d;
  logic                   in_body_q, in_body_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]  out_ctrl_q, out_ctrl_d;
  logic [NUM_CLASSES-1:0] out_wr_q, out_wr_d;
  logic [NUM_CLASSES-1:0] class_pkt_pulse_q, class_pkt_pulse_d;
  logic                   drop_pulse_q, drop_pulse_d;

  logic [CTRL_WIDTH-1:0]  head_ctrl;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   head_is_eop;
  logic                   hdr_ok;
  logic [NUM_CLASSES-1:0] cls_sel;
  logic                   cls_rdy;

  assign head_ctrl   = fifo_head[DATA_WIDTH +: CTRL_WIDTH];
  assign head_data   = fifo_head[DATA_WIDTH-1:0];
  // Any non-zero ctrl after body has started closes the packet.
  assign head_is_eop = in_body_q && (head_ctrl != '0);
  assign hdr_ok      = (head_ctrl == CLASS_CTRL) && ({1'b0, head_data[2:0]} < NUM_CLASSES_L);
  assign cls_sel     = NUM_CLASSES'(1) << cls_q;
  // Only the ready of the class currently being served matters.
  assign cls_rdy     = |(out_rdy & cls_sel);

  // Next-state, pop decision and registered output values.
  always_comb begin
    state_d           = state_q;
    cls_d             = cls_q;
    in_body_d         = in_body_q;
    out_data_d        = out_data_q;
    out_ctrl_d        = out_ctrl_q;
    out_wr_d          = '0;
    class_pkt_pulse_d = '0;
    drop_pulse_d      = 1'b0;
    fifo_pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          in_body_d = 1'b0;
          if (hdr_ok) begin
            // Class header is consumed here and never forwarded.
            fifo_pop = 1'b1;
            cls_d    = head_data[2:0];
            state_d  = ST_FWD;
          end else begin
            // Leave the word in place; DROP consumes it with the rest.
            state_d = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (!fifo_empty && cls_rdy) begin
          fifo_pop   = 1'b1;
          out_data_d = head_data;
          out_ctrl_d = head_ctrl;
          out_wr_d   = cls_sel;
          if (head_ctrl == '0) begin
            in_body_d = 1'b1;
          end
          if (head_is_eop) begin
            class_pkt_pulse_d = cls_sel;
            state_d           = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_ctrl == '0) begin
            in_body_d = 1'b1;
          end
          if (head_is_eop) begin
            drop_pulse_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All control and output registers, with synchronous reset flushing the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      cnt_q             <= '0;
      state_q           <= ST_IDLE;
      cls_q             <= '0;
      in_body_q         <= 1'b0;
      out_data_q        <= '0;
      out_ctrl_q        <= '0;
      out_wr_q          <= '0;
      class_pkt_pulse_q <= '0;
      drop_pulse_q      <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      cnt_q             <= cnt_d;
      state_q           <= state_d;
      cls_q             <= cls_d;
      in_body_q         <= in_body_d;
      out_data_q        <= out_data_d;
      out_ctrl_q        <= out_ctrl_d;
      out_wr_q          <= out_wr_d;
      class_pkt_pulse_q <= class_pkt_pulse_d;
      drop_pulse_q      <= drop_pulse_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_ctrl        = out_ctrl_q;
  assign out_wr          = out_wr_q;
  assign class_pkt_pulse = class_pkt_pulse_q;
  assign drop_pulse      = drop_pulse_q;

endmodule

// File: tb/tb_drr_class_demux.sv
// Bench for drr_class_demux: an ordered event scoreboard built from packet contents,
// checked every cycle, plus directed timing cases and a randomized packet mix.
module tb_drr_class_demux;

  localparam int NC = 5;

  typedef struct {
    bit          drop;
    int          cls;
    logic [7:0]  ctrl;
    logic [63:0] data;
    bit          eop;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   in_data = '0;
  logic [7:0]    in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [63:0]   out_data;
  logic [7:0]    out_ctrl;
  logic [NC-1:0] out_wr;
  logic [NC-1:0] out_rdy = '1;
  logic [NC-1:0] class_pkt_pulse;
  logic          drop_pulse;

  drr_class_demux #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .NUM_CLASSES(NC),
    .CLASS_CTRL(8'h55)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .in_wr(in_wr),
    .in_rdy(in_rdy),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .out_wr(out_wr),
    .out_rdy(out_rdy),
    .class_pkt_pulse(class_pkt_pulse),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int drop_cnt = 0;
  int last_wr_edge = 0;
  int pkt_cnt [NC] = '{default: 0};
  ev_t           exp_q [$];
  int            wr_cyc [$];
  logic [NC-1:0] wr_oh [$];
  logic [63:0]   wr_dat [$];
  int            pulse_cyc [$];
  logic [63:0]   prev_data = '0;
  logic [7:0]    prev_ctrl = '0;

  function automatic logic [NC-1:0] oh(input int c);
    oh = NC'(1) << c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_ev(input bit drop, input int c, input logic [7:0] ct, input logic [63:0] d, input bit eop);
    ev_t e;
    e.drop = drop; e.cls = c; e.ctrl = ct; e.data = d; e.eop = eop;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge after the word was presented.
  task automatic send_word(input logic [7:0] c, input logic [63:0] d, input int gap);
    int t;
    t = 0;
    while (!in_rdy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: in_rdy stayed 0, required 1");
    end else begin
      in_wr = 1'b1; in_ctrl = c; in_data = d;
      last_wr_edge = cyc + 1;
      @(negedge clk);
      in_wr = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Packet = first word, nh extra module headers, nb body words, EOP.
  task automatic send_pkt(input int c, input bit bad, input int nh, input int nb, input int gap);
    logic [7:0]  wc [$];
    logic [63:0] wd [$];
    logic [63:0] d;
    bit drop;
    drop = bad || (c >= NC);
    d = {$urandom, $urandom};
    if (bad) wc.push_back(8'hFF);
    else begin
      wc.push_back(8'h55);
      d[2:0] = 3'(c);
    end
    wd.push_back(d);
    for (int i = 0; i < nh; i++) begin
      wc.push_back(8'($urandom_range(1, 255)));
      wd.push_back({$urandom, $urandom});
    end
    for (int i = 0; i < nb; i++) begin
      wc.push_back(8'h00);
      wd.push_back({$urandom, $urandom});
    end
    wc.push_back(8'(1 << $urandom_range(0, 7)));
    wd.push_back({$urandom, $urandom});
    if (drop) push_ev(1'b1, 0, 8'h00, 64'd0, 1'b1);
    else begin
      for (int i = 1; i < wc.size(); i++)
        push_ev(1'b0, c, wc[i], wd[i], i == wc.size() - 1);
    end
    for (int i = 0; i < wc.size(); i++) send_word(wc[i], wd[i], gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready patterns.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_rdy = '1;
        1: out_rdy = NC'($urandom) | NC'($urandom);
        2: out_rdy = ((cyc % 4 == 0) || (cyc % 4 == 3)) ? 5'b01000 : 5'b00000;
        3: out_rdy = '0;
        default: out_rdy = '1;
      endcase
    end
  end

  // Compare process: every output cycle is checked against the event order.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        prev_data = '0;
        prev_ctrl = '0;
        continue;
      end
      chk("wr_onehot", 64'($countones(out_wr) <= 1), 64'd1);
      chk("wr_without_rdy", 64'(out_wr & ~out_rdy), 64'd0);
      if (out_wr != '0) begin
        wr_cyc.push_back(cyc);
        wr_oh.push_back(out_wr);
        wr_dat.push_back(out_data);
        if (exp_q.size() == 0 || exp_q[0].drop) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got out_wr=%b data=%h, required no write", out_wr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_wr", 64'(out_wr), 64'(oh(e.cls)));
          chk("out_data", out_data, e.data);
          chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          chk("pkt_pulse", 64'(class_pkt_pulse), e.eop ? 64'(oh(e.cls)) : 64'd0);
        end
      end else begin
        chk("hold_data", out_data, prev_data);
        chk("hold_ctrl", 64'(out_ctrl), 64'(prev_ctrl));
        chk("stray_pkt_pulse", 64'(class_pkt_pulse), 64'd0);
      end
      if (class_pkt_pulse != '0) begin
        pulse_cyc.push_back(cyc);
        for (int i = 0; i < NC; i++) if (class_pkt_pulse[i]) pkt_cnt[i]++;
      end
      if (drop_pulse) begin
        chk("drop_order", 64'(exp_q.size() != 0 && exp_q[0].drop), 64'd1);
        if (exp_q.size() != 0 && exp_q[0].drop) void'(exp_q.pop_front());
        drop_cnt++;
      end
      prev_data = out_data;
      prev_ctrl = out_ctrl;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, hdr_edge, n, d0, p0;
    repeat (3) @(negedge clk);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_pulses", 64'({class_pkt_pulse, drop_pulse}), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Class 2 packet, all ready: 5 consecutive words, header stripped.
    rdy_mode = 0;
    base = wr_cyc.size();
    push_ev(1'b0, 2, 8'hFF, 64'h1111_2222_3333_4444, 1'b0);
    push_ev(1'b0, 2, 8'h00, 64'hA000_0000_0000_0001, 1'b0);
    push_ev(1'b0, 2, 8'h00, 64'hA000_0000_0000_0002, 1'b0);
    push_ev(1'b0, 2, 8'h00, 64'hA000_0000_0000_0003, 1'b0);
    push_ev(1'b0, 2, 8'h08, 64'hE0E0_E0E0_E0E0_E0E0, 1'b1);
    send_word(8'h55, 64'hA5A5_0000_0000_0002, 0);
    hdr_edge = last_wr_edge;
    send_word(8'hFF, 64'h1111_2222_3333_4444, 0);
    send_word(8'h00, 64'hA000_0000_0000_0001, 0);
    send_word(8'h00, 64'hA000_0000_0000_0002, 0);
    send_word(8'h00, 64'hA000_0000_0000_0003, 0);
    send_word(8'h08, 64'hE0E0_E0E0_E0E0_E0E0, 0);
    drain();
    chk("t1_word_count", 64'(wr_cyc.size() - base), 64'd5);
    chk("t1_first_latency", 64'(wr_cyc[base]), 64'(hdr_edge + 2));
    chk("t1_consecutive", 64'(wr_cyc[base+4] - wr_cyc[base]), 64'd4);
    chk("t1_first_oh", 64'(wr_oh[base]), 64'b00100);
    chk("t1_first_data", wr_dat[base], 64'h1111_2222_3333_4444);
    chk("t1_pulse_at_eop", 64'(pulse_cyc[pulse_cyc.size()-1]), 64'(wr_cyc[base+4]));
    chk("t1_pkt_cnt2", 64'(pkt_cnt[2]), 64'd1);

    // Back-to-back class 0 then class 4: one idle cycle between bursts.
    base = wr_cyc.size();
    send_pkt(0, 1'b0, 0, 3, 0);
    send_pkt(4, 1'b0, 1, 2, 0);
    drain();
    chk("t2_word_count", 64'(wr_cyc.size() - base), 64'd8);
    chk("t2_idle_gap", 64'(wr_cyc[base+4] - wr_cyc[base+3]), 64'd2);
    chk("t2_first_oh", 64'(wr_oh[base]), 64'b00001);
    chk("t2_second_oh", 64'(wr_oh[base+4]), 64'b10000);
    chk("t2_pkt_cnt0", 64'(pkt_cnt[0]), 64'd1);
    chk("t2_pkt_cnt4", 64'(pkt_cnt[4]), 64'd1);

    // Class 6 and missing-header packets dropped, then class 1 intact.
    base = wr_cyc.size();
    d0 = drop_cnt;
    send_pkt(6, 1'b0, 1, 2, 0);
    send_pkt(1, 1'b1, 1, 2, 0);
    send_pkt(1, 1'b0, 1, 3, 0);
    drain();
    chk("t3_drops", 64'(drop_cnt - d0), 64'd2);
    chk("t3_word_count", 64'(wr_cyc.size() - base), 64'd5);
    chk("t3_oh", 64'(wr_oh[base]), 64'b00010);

    // Class 3 with ready held low until the FIFO fills, then toggling.
    rdy_mode = 3;
    repeat (2) @(negedge clk);
    base = wr_cyc.size();
    send_word(8'h55, 64'h3, 0);
    n = 0;
    while (in_rdy && n < 40) begin
      push_ev(1'b0, 3, 8'h00, 64'(n) + 64'h3300, 1'b0);
      send_word(8'h00, 64'(n) + 64'h3300, 0);
      n++;
    end
    chk("t4_fill_words", 64'(n), 64'd31);
    chk("t4_in_rdy_low", 64'(in_rdy), 64'd0);
    chk("t4_no_write_while_full", 64'(wr_cyc.size() - base), 64'd0);
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      push_ev(1'b0, 3, 8'h00, 64'h4400 + 64'(i), 1'b0);
      send_word(8'h00, 64'h4400 + 64'(i), 0);
    end
    push_ev(1'b0, 3, 8'h02, 64'h4EEE, 1'b1);
    send_word(8'h02, 64'h4EEE, 0);
    drain();
    chk("t4_word_count", 64'(wr_cyc.size() - base), 64'd35);
    chk("t4_pkt_cnt3", 64'(pkt_cnt[3]), 64'd1);

    // Reset after two of six words forwarded, with more words buffered.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    base = wr_cyc.size();
    p0 = pkt_cnt[1];
    for (int i = 0; i < 5; i++) push_ev(1'b0, 1, 8'h00, 64'h5500 + 64'(i), 1'b0);
    push_ev(1'b0, 1, 8'h04, 64'h55EE, 1'b1);
    send_word(8'h55, 64'h1, 0);
    send_word(8'h00, 64'h5500, 0);
    send_word(8'h00, 64'h5501, 0);
    n = 0;
    while (wr_cyc.size() < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_forwarded", 64'(wr_cyc.size() - base), 64'd2);
    rdy_mode = 3;
    repeat (2) @(negedge clk);
    send_word(8'h00, 64'h5502, 0);
    send_word(8'h00, 64'h5503, 0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_out_wr", 64'(out_wr), 64'd0);
    chk("t5_rst_out_data", out_data, 64'd0);
    chk("t5_rst_pulses", 64'({class_pkt_pulse, drop_pulse}), 64'd0);
    reset = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("t5_in_rdy", 64'(in_rdy), 64'd1);
    chk("t5_no_pulse", 64'(pkt_cnt[1]), 64'(p0));
    base = wr_cyc.size();
    send_pkt(1, 1'b0, 0, 3, 0);
    drain();
    chk("t5_clean_words", 64'(wr_cyc.size() - base), 64'd4);
    chk("t5_clean_pulse", 64'(pkt_cnt[1]), 64'(p0 + 1));

    // Input starved: five idle cycles between words.
    base = wr_cyc.size();
    send_pkt(0, 1'b0, 0, 4, 5);
    drain();
    chk("t6_word_count", 64'(wr_cyc.size() - base), 64'd5);
    for (int i = 1; i < 5; i++)
      chk("t6_gap", 64'(wr_cyc[base+i] - wr_cyc[base+i-1]), 64'd6);
    chk("t6_pulse_at_eop", 64'(pulse_cyc[pulse_cyc.size()-1]), 64'(wr_cyc[base+4]));

    // Randomized packet mix with random downstream readiness.
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 1);
      send_pkt($urandom_range(0, 7), ($urandom_range(0, 5) == 0), $urandom_range(0, 2),
               $urandom_range(1, 6), $urandom_range(0, 2));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drr_class_demux.md
# drr_class_demux

Per-class packet demultiplexer for the DRR router output path. It accepts the classified packet stream, reads the 0x55 class module header (queue class in data[2:0]) and strips that word. It then steers the remaining words of the packet to one of NUM_CLASSES per-class output streams, which feed the per-class DRR queues. Packets without a valid class header are discarded and counted through a pulse output for generic_regs.

## Interface
- DATA_WIDTH, 64, datapath width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width
- NUM_CLASSES, 5, number of output class streams (classes 0..NUM_CLASSES-1)
- CLASS_CTRL, 8'h55, ctrl value identifying the class module header

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  input word
- in_ctrl  in  CTRL_WIDTH  input ctrl
- in_wr  in  1  input word valid
- in_rdy  out  1  = !input_fifo nearly_full
- out_data  out  DATA_WIDTH  shared output word, registered
- out_ctrl  out  CTRL_WIDTH  shared output ctrl, registered
- out_wr  out  NUM_CLASSES  one-hot write strobe per class, registered
- out_rdy  in  NUM_CLASSES  per-class ready (downstream nearly_full inverted)
- class_pkt_pulse  out  NUM_CLASSES  1-cycle pulse per forwarded packet, per class
- drop_pulse  out  1  1-cycle pulse per dropped packet

## Operation
- Input buffer: fallthrough_small_fifo, depth 32 (MAX_DEPTH_BITS 5), PROG_FULL_THRESHOLD 31. Head word is valid whenever !empty.
- Packet framing: words with ctrl!=0 before the first ctrl==0 word are module headers. The first word with ctrl!=0 after at least one ctrl==0 word is EOP. Internal in_body flag tracks this.
- FSM states: IDLE, FWD, DROP.
- IDLE, FIFO empty: hold.
- IDLE, head ctrl==CLASS_CTRL and data[2:0]<NUM_CLASSES: latch cls=data[2:0], pop, clear in_body, go FWD. Header word not forwarded.
- IDLE, any other head word: do not pop, clear in_body, go DROP.
- FWD: pop when !empty && out_rdy[cls]. A popped word is registered onto out_data/out_ctrl with out_wr[cls]=1 next cycle.
  - A popped ctrl==0 word sets in_body.
  - Popping the EOP word sets class_pkt_pulse[cls] the next cycle and returns to IDLE.
  - Additional module headers (e.g. 0xFF IOQ header) are forwarded unchanged.
- DROP: pop whenever !empty, no output writes, same in_body tracking. Popping EOP pulses drop_pulse next cycle and returns to IDLE.
- Only one bit of out_wr is ever high. out_data/out_ctrl hold their last value when out_wr==0.
- out_rdy of non-selected classes is ignored. A deasserted out_rdy[cls] stalls only this block; the input FIFO backs up to in_rdy.
- cls holds for the whole packet.

## Timing
- Reset (synchronous): state IDLE, FIFO flushed, in_body=0, cls=0, out_wr=0, out_data=0, out_ctrl=0, class_pkt_pulse=0, drop_pulse=0. Reset mid-packet discards the partial packet with no pulse. The next accepted word is treated as a packet start.
- Latency: word accepted at cycle t (in_wr) becomes the FIFO head at t+1. A popped word appears on the output exactly 1 cycle after its pop.
- For a packet already buffered: class header popped in IDLE at cycle c; first payload word popped at c+1; out_wr at c+2.
- Throughput: 1 word/cycle in FWD/DROP, plus 1 IDLE cycle per packet (the header pop). The IDLE cycle of a dropped packet pops nothing.
- out_rdy[cls] is sampled in the pop cycle. Downstream must absorb 1 word after deasserting rdy (nearly_full semantics).
- class_pkt_pulse/drop_pulse coincide with the cycle the EOP word is on the output (or would be, for a drop).
- EOP and the next packet's header are never popped in the same cycle.
- FIFO empty mid-packet: stall in FWD/DROP, no out_wr, no pulse.

## Test plan
- Class 2 packet [0x55 data=...0002, 0xFF hdr, 3×ctrl 0x00, ctrl 0x08 EOP], all out_rdy=1 -> 5 words on out_wr=5'b00100 in consecutive cycles; 0x55 word absent; class_pkt_pulse=5'b00100 once, with EOP.
- Back-to-back packets of class 0 then class 4 -> out_wr 5'b00001 burst, one idle cycle, then 5'b10000 burst; two correct pulses; no word crossover.
- Packet with class 6, then packet with first word ctrl 0xFF (no 0x55) -> no out_wr at all; drop_pulse twice; a following class 1 packet is forwarded intact.
- Class 3 packet with out_rdy[3] toggling 1,0,0,1… and out_rdy[0..2,4]=0 -> words delivered in order only after rdy-high cycles; none lost or duplicated; in_rdy falls after 31 buffered words with out_rdy[3] held 0.
- Reset asserted after 2 of 6 words forwarded -> outputs 0 the next cycle; no pulse; the next clean packet forwards correctly.
- Input starved mid-packet (in_wr gaps of 5 cycles) -> out_wr gaps match; pulse only at EOP.
